nx_node_inbound: RTL and testbench
==================================

NX_NODE_INBOUND -- requirements
Module: nx_node_inbound

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 10, RAM row address width.
REQ-002 SHALL have parameter RAM_DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of inbound message buffer entries.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named i_clk and i_rst.
REQ-005 Ports SHALL be (name  direction  width  meaning):
  i_clk  in  1  clock
  i_rst  in  1  asynchronous active-low reset
  i_node_id  in  node_id_t  this node's row/column
  i_slot  in  1  current slot from the execution core
  i_hold  in  1  execution core owns the data RAM port; no data or instruction writes issue
  i_msg_data  in  node_message_t  inbound message: header.target, header.command, address[10:0], slot[1:0], data[7:0]
  i_msg_valid  in  1  message valid
  o_msg_ready  out  1  message accepted when valid & ready
  o_data_addr  out  RAM_ADDR_W  data RAM row
  o_data_wr_data  out  RAM_DATA_W  data RAM write data
  o_data_wr_strb  out  RAM_DATA_W  data RAM per-bit write strobe
  o_inst_addr  out  RAM_ADDR_W  instruction RAM address
  o_inst_wr_data  out  RAM_DATA_W  instruction word
  o_inst_wr_en  out  1  instruction RAM write enable
  o_loaded  out  RAM_ADDR_W+1  count of instruction words written
  o_idle  out  1  FIFO empty, no partial instruction word, no write in flight
  o_error  out  1  one-cycle pulse on a dropped message

Function
REQ-006 o_msg_ready SHALL equal "FIFO not full"; it SHALL NOT depend combinationally on i_msg_valid or i_hold.
REQ-007 An accepted message SHALL enter the FIFO tail in cycle N. The head SHALL pop no earlier than N+1, and only when i_hold is low. The resulting RAM write outputs SHALL be registered and asserted in the cycle after the pop.
REQ-008 Throughput SHALL be one message per cycle; a simultaneous push and pop when full SHALL NOT be permitted, because ready is low when full.
REQ-009 Popped message with header.target != i_node_id, or with a command other than NODE_COMMAND_SIGNAL or NODE_COMMAND_LOAD, SHALL be discarded with a single o_error pulse and no RAM write.
REQ-010 SIGNAL: the resolved slot bit SHALL be i_slot for SLOT_PRESERVE, ~i_slot for SLOT_INVERSE, 0 for SLOT_LOWER and 1 for SLOT_UPPER. i_slot SHALL be sampled at pop.
REQ-011 SIGNAL: the byte lane SHALL be L = {address[0], resolved slot} and the row SHALL be address[10:1]. o_data_wr_data SHALL be {4{data}} and o_data_wr_strb SHALL be 0xFF << (8*L).
REQ-012 o_data_wr_strb SHALL be all-zero in every cycle without a SIGNAL write; o_data_addr and o_data_wr_data are don't-care then.
REQ-013 LOAD: data bytes SHALL accumulate LSB-first into a 32-bit word under a 2-bit byte counter. On the 4th byte, o_inst_wr_en SHALL pulse one cycle with o_inst_addr = load pointer, then the pointer and o_loaded SHALL increment.
REQ-014 The load pointer SHALL wrap from 2^RAM_ADDR_W-1 to 0. o_loaded SHALL saturate at 2^RAM_ADDR_W.
REQ-015 LOAD address and slot fields SHALL be ignored.
REQ-016 SIGNAL messages interleaved between LOAD bytes SHALL NOT disturb the partial word or the byte counter.
REQ-017 While i_hold is high, the FIFO SHALL retain its contents, no write strobe or enable SHALL assert, and accepting SHALL continue until full.
REQ-018 o_idle SHALL be high only when the FIFO is empty, the byte counter is 0, and no write output is asserted.

Reset
REQ-019 Asserting i_rst low SHALL immediately clear the FIFO, the byte counter, the partial word, the load pointer and o_loaded, regardless of clock.
REQ-020 During reset: o_inst_wr_en=0, o_data_wr_strb=0, o_error=0, o_idle=1, o_msg_ready=1, and all address/data outputs are 0.
REQ-021 A reset asserted mid-word SHALL discard the partial word; the next LOAD byte after reset SHALL become byte 0 at address 0.

Verification
REQ-022 SIGNAL to own ID, address 0x00B, SLOT_INVERSE, data 0xA5, i_slot=0, accepted cycle N -> in N+2: o_data_addr=5, o_data_wr_strb=0xFF000000, o_data_wr_data=0xA5A5A5A5.
REQ-023 Eight LOAD bytes 0x11..0x88 back-to-back -> writes 0x44332211 at address 0, then 0x88776655 at address 1; o_loaded=2; o_idle=1 afterwards.
REQ-024 i_hold high, three messages offered -> two accepted, o_msg_ready low, no writes. Release i_hold -> writes drain in order, and the third message is accepted in the cycle after the first pop.
REQ-025 SIGNAL with a wrong target row, then an unknown command -> two o_error pulses, zero strobes, byte counter unchanged.
REQ-026 Two LOAD bytes, SIGNAL (SLOT_UPPER, address 0), two LOAD bytes -> one SIGNAL write with strobe 0x0000FF00 and one instruction word containing the four LOAD bytes in order.
REQ-027 Reset pulse after three LOAD bytes, then four bytes 0x01..0x04 -> 0x04030201 written at address 0, o_loaded=1.

Source files
------------

// File: rtl/nx_node_inbound.sv
// Inbound message unit: buffers node messages and turns them into data/instruction RAM writes.
// Latency: accepted in N, popped no earlier than N+1, registered RAM write visible in N+2.
// Backpressure: o_msg_ready is FIFO-not-full only; i_hold stalls the pop, not the accept.

package nx_node_pkg;
    typedef struct packed {
        logic [3:0] row;
        logic [3:0] column;
    } node_id_t;

    typedef enum logic [1:0] {
        NODE_COMMAND_LOAD   = 2'd0,
        NODE_COMMAND_SIGNAL = 2'd1,
        NODE_COMMAND_RSVD2  = 2'd2,
        NODE_COMMAND_RSVD3  = 2'd3
    } node_command_t;

    typedef enum logic [1:0] {
        SLOT_PRESERVE = 2'd0,
        SLOT_INVERSE  = 2'd1,
        SLOT_LOWER    = 2'd2,
        SLOT_UPPER    = 2'd3
    } slot_sel_t;

    typedef struct packed {
        node_id_t      target;
        node_command_t command;
    } node_header_t;

    typedef struct packed {
        node_header_t header;
        logic [10:0]  address;
        slot_sel_t    slot;
        logic [7:0]   data;
    } node_message_t;
endpackage

// Generic synchronous FIFO with registered storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push_rdy low when full; no push-through on a simultaneous pop.
module nx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count != CNT_W'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage; emptiness is tracked by count, so contents need no reset.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module nx_node_inbound
    import nx_node_pkg::*;
#(
    parameter int RAM_ADDR_W = 10,
    parameter int RAM_DATA_W = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  node_id_t              i_node_id,
    input  logic                  i_slot,
    input  logic                  i_hold,
    input  node_message_t         i_msg_data,
    input  logic                  i_msg_valid,
    output logic                  o_msg_ready,
    output logic [RAM_ADDR_W-1:0] o_data_addr,
    output logic [RAM_DATA_W-1:0] o_data_wr_data,
    output logic [RAM_DATA_W-1:0] o_data_wr_strb,
    output logic [RAM_ADDR_W-1:0] o_inst_addr,
    output logic [RAM_DATA_W-1:0] o_inst_wr_data,
    output logic                  o_inst_wr_en,
    output logic [RAM_ADDR_W:0]   o_loaded,
    output logic                  o_idle,
    output logic                  o_error
);
    localparam int MSG_W = $bits(node_message_t);

    logic [MSG_W-1:0]      head_dat;
    node_message_t         head;
    logic                  head_vld;
    logic                  pop;
    logic                  target_ok;
    logic                  is_sig;
    logic                  is_load;
    logic                  slot_bit;
    logic [1:0]            lane;
    logic [31:0]           strb_lane;

    logic [RAM_ADDR_W-1:0] data_addr_q;
    logic [RAM_DATA_W-1:0] data_wr_data_q;
    logic [RAM_DATA_W-1:0] data_wr_strb_q;
    logic [RAM_ADDR_W-1:0] inst_addr_q;
    logic [RAM_DATA_W-1:0] inst_wr_data_q;
    logic                  inst_wr_en_q;
    logic [RAM_ADDR_W-1:0] load_ptr;
    logic [RAM_ADDR_W:0]   loaded_q;
    logic [1:0]            byte_cnt;
    logic [23:0]           partial_word;
    logic                  error_q;

    nx_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push_vld (i_msg_valid),
        .push_dat (i_msg_data),
        .push_rdy (o_msg_ready),
        .pop_vld  (head_vld),
        .pop_dat  (head_dat),
        .pop_rdy  (!i_hold)
    );

    assign head      = node_message_t'(head_dat);
    assign pop       = head_vld && !i_hold;
    assign target_ok = (head.header.target == i_node_id);
    assign is_sig    = target_ok && (head.header.command == NODE_COMMAND_SIGNAL);
    assign is_load   = target_ok && (head.header.command == NODE_COMMAND_LOAD);

    // Resolve the slot bit of a SIGNAL against the core's slot at pop time.
    always_comb begin
        slot_bit = 1'b0;
        case (head.slot)
            SLOT_PRESERVE: slot_bit = i_slot;
            SLOT_INVERSE:  slot_bit = ~i_slot;
            SLOT_LOWER:    slot_bit = 1'b0;
            SLOT_UPPER:    slot_bit = 1'b1;
            default:       slot_bit = 1'b0;
        endcase
    end

    assign lane      = {head.address[0], slot_bit};
    assign strb_lane = 32'h0000_00FF << {lane, 3'b000};

    // SIGNAL path: one registered byte-lane write per popped SIGNAL; strobe idles at zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_addr_q    <= '0;
            data_wr_data_q <= '0;
            data_wr_strb_q <= '0;
        end else begin
            data_wr_strb_q <= '0;
            if (pop && is_sig) begin
                data_addr_q    <= RAM_ADDR_W'(head.address[10:1]);
                data_wr_data_q <= RAM_DATA_W'({4{head.data}});
                data_wr_strb_q <= RAM_DATA_W'(strb_lane);
            end
        end
    end

    // LOAD path: gather bytes LSB-first; the fourth byte emits the word and advances the pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            byte_cnt       <= '0;
            partial_word   <= '0;
            inst_wr_en_q   <= 1'b0;
            inst_addr_q    <= '0;
            inst_wr_data_q <= '0;
            load_ptr       <= '0;
            loaded_q       <= '0;
        end else begin
            inst_wr_en_q <= 1'b0;
            if (pop && is_load) begin
                byte_cnt <= byte_cnt + 1'b1;
                case (byte_cnt)
                    2'd0: partial_word[7:0]   <= head.data;
                    2'd1: partial_word[15:8]  <= head.data;
                    2'd2: partial_word[23:16] <= head.data;
                    default: begin
                        inst_wr_en_q   <= 1'b1;
                        inst_addr_q    <= load_ptr;
                        inst_wr_data_q <= RAM_DATA_W'({head.data, partial_word});
                        load_ptr       <= load_ptr + 1'b1;
                        // Counter stops once every RAM row has been written at least once.
                        if (!loaded_q[RAM_ADDR_W]) begin
                            loaded_q <= loaded_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Drop flag: wrong target or a command this unit does not handle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= pop && !(is_sig || is_load);
        end
    end

    assign o_data_addr    = data_addr_q;
    assign o_data_wr_data = data_wr_data_q;
    assign o_data_wr_strb = data_wr_strb_q;
    assign o_inst_addr    = inst_addr_q;
    assign o_inst_wr_data = inst_wr_data_q;
    assign o_inst_wr_en   = inst_wr_en_q;
    assign o_loaded       = loaded_q;
    assign o_error        = error_q;
    assign o_idle         = !head_vld && (byte_cnt == 2'd0) && !inst_wr_en_q
                            && (data_wr_strb_q == '0);
endmodule

// File: tb/tb_nx_node_inbound.sv
module tb_nx_node_inbound;
    import nx_node_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam logic [7:0] OWN   = 8'h35;
    localparam logic [7:0] WRONG = 8'h45;

    logic          clk = 1'b0;
    logic          rst_n;
    node_id_t      node_id;
    logic          slot;
    logic          hold;
    node_message_t msg;
    logic          msg_valid;
    logic          msg_ready;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wr_data;
    logic [DW-1:0] data_wr_strb;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_wr_data;
    logic          inst_wr_en;
    logic [AW:0]   loaded;
    logic          idle;
    logic          error;

    always #5 clk = ~clk;

    nx_node_inbound #(
        .RAM_ADDR_W (AW),
        .RAM_DATA_W (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_node_id      (node_id),
        .i_slot         (slot),
        .i_hold         (hold),
        .i_msg_data     (msg),
        .i_msg_valid    (msg_valid),
        .o_msg_ready    (msg_ready),
        .o_data_addr    (data_addr),
        .o_data_wr_data (data_wr_data),
        .o_data_wr_strb (data_wr_strb),
        .o_inst_addr    (inst_addr),
        .o_inst_wr_data (inst_wr_data),
        .o_inst_wr_en   (inst_wr_en),
        .o_loaded       (loaded),
        .o_idle         (idle),
        .o_error        (error)
    );

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [DW-1:0] strb;
    } sig_t;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } ins_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rand_on = 1'b0;

    // reference model state
    node_message_t mq[$];
    logic [7:0]    lbytes[$];
    int            m_ptr;
    int            m_loaded;
    bit            m_wrote;
    int            last_acc_cyc;
    logic          rdy_e;
    logic          idle_e;
    node_message_t mh;

    // scoreboard queues and logs of observed writes
    sig_t exp_sig[$];
    ins_t exp_ins[$];
    int   exp_err[$];
    sig_t sig_log[$];
    ins_t ins_log[$];
    int   err_seen = 0;
    int   last_sig_cyc;
    sig_t mon_s;
    sig_t mon_se;
    ins_t mon_i;
    ins_t mon_ie;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Apply the spec rules to one popped message and queue the response due next cycle.
    task automatic model_pop(input node_message_t h, input logic cur_slot);
        logic          s;
        int            ln;
        logic [10:0]   row;
        logic [DW-1:0] strb;
        if (h.header.target != node_id ||
            !(h.header.command == NODE_COMMAND_SIGNAL || h.header.command == NODE_COMMAND_LOAD)) begin
            exp_err.push_back(cyc + 1);
        end else if (h.header.command == NODE_COMMAND_SIGNAL) begin
            case (h.slot)
                SLOT_PRESERVE: s = cur_slot;
                SLOT_INVERSE:  s = !cur_slot;
                SLOT_LOWER:    s = 1'b0;
                default:       s = 1'b1;
            endcase
            ln = 2 * int'(h.address[0]) + int'(s);
            for (int k = 0; k < 4; k++) strb[8*k +: 8] = (k == ln) ? 8'hFF : 8'h00;
            row = h.address / 2;
            exp_sig.push_back('{cyc + 1, row[AW-1:0], {h.data, h.data, h.data, h.data}, strb});
            m_wrote = 1'b1;
        end else begin
            lbytes.push_back(h.data);
            if (lbytes.size() == 4) begin
                exp_ins.push_back('{cyc + 1, AW'(m_ptr), {lbytes[3], lbytes[2], lbytes[1], lbytes[0]}});
                m_ptr = (m_ptr + 1) % (1 << AW);
                if (m_loaded < (1 << AW)) m_loaded++;
                lbytes.delete();
                m_wrote = 1'b1;
            end
        end
    endtask

    // Reference model: FIFO occupancy, pop rule, ready/idle expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            lbytes.delete();
            exp_sig.delete();
            exp_ins.delete();
            exp_err.delete();
            m_ptr = 0;
            m_loaded = 0;
            m_wrote = 1'b0;
            chk("rst_ready", msg_ready, 1);
            chk("rst_idle", idle, 1);
            chk("rst_strb", data_wr_strb, 0);
            chk("rst_inst_en", inst_wr_en, 0);
            chk("rst_error", error, 0);
            chk("rst_loaded", loaded, 0);
            chk("rst_addrs", {data_addr, inst_addr}, 0);
            chk("rst_data", {data_wr_data, inst_wr_data}, 0);
        end else begin
            rdy_e  = (mq.size() < DEPTH);
            idle_e = (mq.size() == 0) && (lbytes.size() == 0) && !m_wrote;
            chk("ready", msg_ready, rdy_e);
            chk("idle", idle, idle_e);
            m_wrote = 1'b0;
            if (mq.size() > 0 && !hold) begin
                mh = mq.pop_front();
                model_pop(mh, slot);
            end
            if (msg_valid && rdy_e) begin
                mq.push_back(msg);
                last_acc_cyc = cyc;
            end
        end
    end

    // Monitor: compare every presented write/error against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_sig.size() > 0 && exp_sig[0].due < cyc) begin
                chk("sig_missing", cyc, exp_sig[0].due);
                void'(exp_sig.pop_front());
            end
            while (exp_ins.size() > 0 && exp_ins[0].due < cyc) begin
                chk("ins_missing", cyc, exp_ins[0].due);
                void'(exp_ins.pop_front());
            end
            while (exp_err.size() > 0 && exp_err[0] < cyc) begin
                chk("err_missing", cyc, exp_err[0]);
                void'(exp_err.pop_front());
            end
            if (data_wr_strb != '0) begin
                mon_s = '{cyc, data_addr, data_wr_data, data_wr_strb};
                sig_log.push_back(mon_s);
                last_sig_cyc = cyc;
                if (exp_sig.size() == 0) begin
                    chk("sig_unexpected", data_wr_strb, 0);
                end else begin
                    mon_se = exp_sig.pop_front();
                    chk("sig_cycle", cyc, mon_se.due);
                    chk("sig_addr", data_addr, mon_se.addr);
                    chk("sig_data", data_wr_data, mon_se.dat);
                    chk("sig_strb", data_wr_strb, mon_se.strb);
                end
            end
            if (inst_wr_en) begin
                mon_i = '{cyc, inst_addr, inst_wr_data};
                ins_log.push_back(mon_i);
                if (exp_ins.size() == 0) begin
                    chk("ins_unexpected", inst_wr_en, 0);
                end else begin
                    mon_ie = exp_ins.pop_front();
                    chk("ins_cycle", cyc, mon_ie.due);
                    chk("ins_addr", inst_addr, mon_ie.addr);
                    chk("ins_data", inst_wr_data, mon_ie.dat);
                end
            end
            if (error) begin
                err_seen++;
                if (exp_err.size() == 0) begin
                    chk("err_unexpected", error, 0);
                end else begin
                    chk("err_cycle", cyc, exp_err.pop_front());
                end
            end
        end
    end

    function automatic node_message_t mk(input logic [7:0] tgt, input node_command_t c,
                                         input logic [10:0] a, input slot_sel_t s, input logic [7:0] d);
        node_message_t m;
        m.header.target  = tgt;
        m.header.command = c;
        m.address        = a;
        m.slot           = s;
        m.data           = d;
        return m;
    endfunction

    function automatic node_message_t rand_msg();
        int            r;
        node_command_t c;
        logic [7:0]    tgt;
        tgt = ($urandom_range(0, 4) == 0) ? 8'($urandom) : OWN;
        r = $urandom_range(0, 99);
        if (r < 45)      c = NODE_COMMAND_LOAD;
        else if (r < 85) c = NODE_COMMAND_SIGNAL;
        else if (r < 93) c = NODE_COMMAND_RSVD2;
        else             c = NODE_COMMAND_RSVD3;
        return mk(tgt, c, 11'($urandom), slot_sel_t'($urandom_range(0, 3)), 8'($urandom));
    endfunction

    task automatic rand_inputs();
        hold = ($urandom_range(0, 3) == 0);
        slot = 1'($urandom_range(0, 1));
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_on) rand_inputs();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input node_message_t m);
        logic got;
        got = 1'b0;
        msg = m;
        msg_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rand_on) rand_inputs();
            @(negedge clk);
            got = msg_ready;
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
        chk("send_accept", got, 1);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ebase;
        int rel_cyc;
        int acc_cyc;
        logic got;

        rst_n     = 1'b0;
        node_id   = OWN;
        slot      = 1'b0;
        hold      = 1'b0;
        msg_valid = 1'b0;
        msg       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // SIGNAL known answer: inverse slot, odd address -> top lane, row 5, two-cycle latency
        base = sig_log.size();
        slot = 1'b0;
        send(mk(OWN, NODE_COMMAND_SIGNAL, 11'h00B, SLOT_INVERSE, 8'hA5));
        idle_cycles(4);
        chk("kat_sig_count", sig_log.size(), base + 1);
        if (sig_log.size() > base) begin
            chk("kat_sig_addr", sig_log[base].addr, 5);
            chk("kat_sig_strb", sig_log[base].strb, 32'hFF00_0000);
            chk("kat_sig_data", sig_log[base].dat, 32'hA5A5_A5A5);
            chk("kat_sig_latency", last_sig_cyc, last_acc_cyc + 2);
        end

        // Eight LOAD bytes back to back -> two words
        base = ins_log.size();
        for (int k = 1; k <= 8; k++) send(mk(OWN, NODE_COMMAND_LOAD, 11'($urandom), SLOT_UPPER, 8'(k * 8'h11)));
        idle_cycles(4);
        chk("kat_load_count", ins_log.size(), base + 2);
        if (ins_log.size() >= base + 2) begin
            chk("kat_load0_addr", ins_log[base].addr, 0);
            chk("kat_load0_data", ins_log[base].dat, 32'h4433_2211);
            chk("kat_load1_addr", ins_log[base + 1].addr, 1);
            chk("kat_load1_data", ins_log[base + 1].dat, 32'h8877_6655);
        end
        chk("kat_loaded2", loaded, 2);
        chk("kat_idle_after_load", idle, 1);

        // Dropped messages between LOAD bytes keep the partial word intact
        base  = ins_log.size();
        ebase = err_seen;
        send(mk(OWN, NODE_COMMAND_LOAD, 11'h000, SLOT_LOWER, 8'h31));
        send(mk(WRONG, NODE_COMMAND_SIGNAL, 11'h004, SLOT_LOWER, 8'h77));
        send(mk(OWN, NODE_COMMAND_RSVD2, 11'h004, SLOT_LOWER, 8'h78));
        idle_cycles(4);
        chk("drop_errors", err_seen - ebase, 2);
        chk("drop_partial_held", idle, 0);
        for (int k = 2; k <= 4; k++) send(mk(OWN, NODE_COMMAND_LOAD, 11'h7FF, SLOT_LOWER, 8'(8'h30 + k)));
        idle_cycles(4);
        chk("drop_word_count", ins_log.size(), base + 1);
        if (ins_log.size() > base) begin
            chk("drop_word_data", ins_log[base].dat, 32'h3433_3231);
            chk("drop_word_addr", ins_log[base].addr, 2);
        end

        // SIGNAL interleaved between LOAD bytes
        base  = ins_log.size();
        ebase = sig_log.size();
        send(mk(OWN, NODE_COMMAND_LOAD, 11'h123, SLOT_LOWER, 8'h41));
        send(mk(OWN, NODE_COMMAND_LOAD, 11'h456, SLOT_LOWER, 8'h42));
        send(mk(OWN, NODE_COMMAND_SIGNAL, 11'h000, SLOT_UPPER, 8'h5A));
        send(mk(OWN, NODE_COMMAND_LOAD, 11'h789, SLOT_LOWER, 8'h43));
        send(mk(OWN, NODE_COMMAND_LOAD, 11'h000, SLOT_LOWER, 8'h44));
        idle_cycles(4);
        chk("mix_sig_count", sig_log.size(), ebase + 1);
        if (sig_log.size() > ebase) chk("mix_sig_strb", sig_log[ebase].strb, 32'h0000_FF00);
        chk("mix_word_count", ins_log.size(), base + 1);
        if (ins_log.size() > base) chk("mix_word_data", ins_log[base].dat, 32'h4443_4241);

        // Hold: two accepted, third waits; release pops in order and accepts the third one cycle later
        base = sig_log.size();
        hold = 1'b1;
        send(mk(OWN, NODE_COMMAND_SIGNAL, 11'h010, SLOT_LOWER, 8'hAA));
        send(mk(OWN, NODE_COMMAND_SIGNAL, 11'h012, SLOT_LOWER, 8'hBB));
        msg = mk(OWN, NODE_COMMAND_SIGNAL, 11'h014, SLOT_LOWER, 8'hCC);
        msg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ready_low", msg_ready, 0);
            @(posedge clk);
            #1;
        end
        chk("hold_no_writes", sig_log.size(), base);
        hold = 1'b0;
        rel_cyc = cyc;
        acc_cyc = -1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = msg_ready;
            if (got) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
        chk("hold_third_accept", acc_cyc, rel_cyc + 1);
        idle_cycles(6);
        chk("hold_drain_count", sig_log.size(), base + 3);
        if (sig_log.size() >= base + 3) begin
            chk("hold_order0", sig_log[base].dat, 32'hAAAA_AAAA);
            chk("hold_order1", sig_log[base + 1].dat, 32'hBBBB_BBBB);
            chk("hold_order2", sig_log[base + 2].dat, 32'hCCCC_CCCC);
        end

        // Reset mid-word discards the partial word and restarts at address 0
        for (int k = 0; k < 3; k++) send(mk(OWN, NODE_COMMAND_LOAD, 11'h000, SLOT_LOWER, 8'(8'hE1 + k)));
        idle_cycles(4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_idle", idle, 1);
        chk("async_rst_loaded", loaded, 0);
        chk("async_rst_ready", msg_ready, 1);
        @(posedge clk);
        #1;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        base = ins_log.size();
        for (int k = 1; k <= 4; k++) send(mk(OWN, NODE_COMMAND_LOAD, 11'h3FF, SLOT_UPPER, 8'(k)));
        idle_cycles(4);
        chk("rst_word_count", ins_log.size(), base + 1);
        if (ins_log.size() > base) begin
            chk("rst_word_addr", ins_log[base].addr, 0);
            chk("rst_word_data", ins_log[base].dat, 32'h0403_0201);
        end
        chk("rst_loaded1", loaded, 1);

        // Randomized traffic with random hold and slot
        rand_on = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            send(rand_msg());
        end
        rand_on = 1'b0;
        hold = 1'b0;
        idle_cycles(8);

        // Pointer wrap and o_loaded saturation
        reset_pulse();
        for (int n = 0; n < 4 * (1 << AW); n++) send(mk(OWN, NODE_COMMAND_LOAD, 11'($urandom), SLOT_LOWER, 8'($urandom)));
        idle_cycles(4);
        chk("sat_loaded_full", loaded, 1 << AW);
        base = ins_log.size();
        for (int n = 0; n < 4; n++) send(mk(OWN, NODE_COMMAND_LOAD, 11'($urandom), SLOT_LOWER, 8'($urandom)));
        idle_cycles(4);
        chk("sat_loaded_hold", loaded, 1 << AW);
        chk("wrap_word_count", ins_log.size(), base + 1);
        if (ins_log.size() > base) chk("wrap_addr", ins_log[base].addr, 0);

        chk("left_sig", exp_sig.size(), 0);
        chk("left_ins", exp_ins.size(), 0);
        chk("left_err", exp_err.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
